// File: rtl/r200_pkg.sv
// Shared encodings for the r200 execute stage: func3 ALU/branch/MDU selects and FSM states.
package r200_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/r200ex_stage_if.sv
// Operation/result handshake bundle between the issue logic and the r200 execute stage.
interface r200ex_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      func3;
  logic            alu_cont;
  logic            is_branch;
  logic            is_mdu;
  logic [XLEN-1:0] jump_imm;
  logic [XLEN-1:0] jump_addimm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_jumptarg;
  logic            willbr;

  modport master (
    output in_valid, op1, op2, func3, alu_cont, is_branch, is_mdu,
           jump_imm, jump_addimm, flush, out_ready,
    input  in_ready, out_valid, alu_res, pc_jumptarg, willbr
  );

  modport slave (
    input  in_valid, op1, op2, func3, alu_cont, is_branch, is_mdu,
           jump_imm, jump_addimm, flush, out_ready,
    output in_ready, out_valid, alu_res, pc_jumptarg, willbr
  );
endinterface

// File: rtl/r200ex_mdu.sv
// Iterative M-extension unit: shift-add multiply / restoring divide on magnitudes, sign fixed at the end.
module r200ex_mdu
  import r200_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MDU_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int unsigned STEPS = (XLEN + MDU_CYCLES - 1) / MDU_CYCLES;
  localparam int unsigned CW    = $clog2(MDU_CYCLES + 1);

  logic              run;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p, p_nxt, full;
  logic [XLEN-1:0]   mag_b, a_save, quo, rem, result_nxt;
  logic [2:0]        fn;
  logic              neg_q, neg_r, div0;
  logic [XLEN:0]     t, sum;
  logic              sa, sb, a_neg, b_neg;

  assign sa    = (func3 == F3_MULH) || (func3 == F3_MULHSU) || (func3 == F3_DIV) || (func3 == F3_REM);
  assign sb    = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
  assign a_neg = sa && op_a[XLEN-1];
  assign b_neg = sb && op_b[XLEN-1];
  assign done  = run && (cnt == CW'(MDU_CYCLES - 1));

  // p is {product_hi, product_lo} for multiply and {remainder, quotient} for divide
  always_comb begin
    p_nxt = p;
    t     = '0;
    sum   = '0;
    for (int unsigned s = 0; s < STEPS; s++) begin
      if (32'(cnt) * STEPS + s < XLEN) begin
        if (fn[2]) begin
          t = p_nxt[2*XLEN-1:XLEN-1];
          if (t >= {1'b0, mag_b}) begin
            t     = t - {1'b0, mag_b};
            p_nxt = {t[XLEN-1:0], p_nxt[XLEN-2:0], 1'b1};
          end else begin
            p_nxt = {t[XLEN-1:0], p_nxt[XLEN-2:0], 1'b0};
          end
        end else begin
          sum   = {1'b0, p_nxt[2*XLEN-1:XLEN]} + (p_nxt[0] ? {1'b0, mag_b} : '0);
          p_nxt = {sum, p_nxt[XLEN-1:1]};
        end
      end
    end
  end

  always_comb begin
    full       = neg_q ? -p_nxt : p_nxt;
    quo        = neg_q ? -p_nxt[XLEN-1:0] : p_nxt[XLEN-1:0];
    rem        = neg_r ? -p_nxt[2*XLEN-1:XLEN] : p_nxt[2*XLEN-1:XLEN];
    result_nxt = '0;
    if (!fn[2]) begin
      result_nxt = (fn == F3_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end else if (div0) begin
      result_nxt = fn[1] ? a_save : '1;
    end else begin
      result_nxt = fn[1] ? rem : quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      p      <= '0;
      mag_b  <= '0;
      a_save <= '0;
      fn     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      result <= '0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      p      <= {{XLEN{1'b0}}, (a_neg ? -op_a : op_a)};
      mag_b  <= b_neg ? -op_b : op_b;
      a_save <= op_a;
      fn     <= func3;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= (op_b == '0);
    end else if (run) begin
      p <= p_nxt;
      if (done) begin
        run    <= 1'b0;
        cnt    <= '0;
        result <= result_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/r200ex_stage.sv
// r200 execute stage: single-cycle ALU/branch/jump-target with registered output handshake.
// Optional iterative multiply/divide enabled by defining R200EX_MDU_EN.
module r200ex_stage
  import r200_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MDU_CYCLES = XLEN
) (
  input logic           clk,
  input logic           rst_n,
  r200ex_stage_if.slave ex
);
  localparam int unsigned SHW = $clog2(XLEN);

  ex_state_t       state, state_nxt;
  logic            busy, accept, out_fire, mdu_go, mdu_done;
  logic            valid_q, valid_nxt;
  logic [XLEN-1:0] alu_val, alu_q, pc_q, mdu_res;
  logic            br_val, br_q;
  logic [SHW-1:0]  shamt;

  assign busy         = (state == BUSY);
  assign ex.in_ready  = rst_n && !ex.flush && !busy && (!valid_q || ex.out_ready);
  assign accept       = ex.in_valid && ex.in_ready;
  assign out_fire     = valid_q && ex.out_ready;
  assign shamt        = ex.op2[SHW-1:0];

  assign ex.out_valid   = valid_q;
  assign ex.alu_res     = (state == DONE) ? mdu_res : alu_q;
  assign ex.pc_jumptarg = pc_q;
  assign ex.willbr      = br_q;

`ifdef R200EX_MDU_EN
  assign mdu_go = accept && ex.is_mdu;

  r200ex_mdu #(
    .XLEN      (XLEN),
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_go),
    .kill  (ex.flush),
    .func3 (ex.func3),
    .op_a  (ex.op1),
    .op_b  (ex.op2),
    .done  (mdu_done),
    .result(mdu_res)
  );
`else
  localparam int unsigned unused_mdu_cycles = MDU_CYCLES;
  logic unused_is_mdu;
  assign unused_is_mdu = ex.is_mdu;
  assign mdu_go        = 1'b0;
  assign mdu_done      = 1'b0;
  assign mdu_res       = '0;
`endif

  always_comb begin
    alu_val = '0;
    unique case (ex.func3)
      F3_ADD:  alu_val = ex.alu_cont ? ex.op1 - ex.op2 : ex.op1 + ex.op2;
      F3_SLL:  alu_val = ex.op1 << shamt;
      F3_SLT:  alu_val[0] = $signed(ex.op1) < $signed(ex.op2);
      F3_SLTU: alu_val[0] = ex.op1 < ex.op2;
      F3_XOR:  alu_val = ex.op1 ^ ex.op2;
      F3_SRL:  alu_val = ex.alu_cont ? $unsigned($signed(ex.op1) >>> shamt) : ex.op1 >> shamt;
      F3_OR:   alu_val = ex.op1 | ex.op2;
      F3_AND:  alu_val = ex.op1 & ex.op2;
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    br_val = 1'b0;
    unique case (ex.func3)
      F3_BEQ:  br_val = ex.op1 == ex.op2;
      F3_BNE:  br_val = ex.op1 != ex.op2;
      F3_BLT:  br_val = $signed(ex.op1) < $signed(ex.op2);
      F3_BGE:  br_val = $signed(ex.op1) >= $signed(ex.op2);
      F3_BLTU: br_val = ex.op1 < ex.op2;
      F3_BGEU: br_val = ex.op1 >= ex.op2;
      default: br_val = 1'b0;
    endcase
  end

  // flush overrides both the output handshake and MDU completion
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    unique case (state)
      IDLE: if (mdu_go) state_nxt = BUSY;
      BUSY: if (mdu_done) state_nxt = DONE;
      DONE: if (out_fire) state_nxt = mdu_go ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (accept && !mdu_go)   valid_nxt = 1'b1;
    else if (busy && mdu_done) valid_nxt = 1'b1;
    else if (out_fire)       valid_nxt = 1'b0;
    if (ex.flush) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      alu_q   <= '0;
      pc_q    <= '0;
      br_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      if (accept) begin
        alu_q <= alu_val;
        pc_q  <= ex.jump_imm + ex.jump_addimm;
        br_q  <= ex.is_branch && br_val;
      end
    end
  end
endmodule

// File: tb/tb_r200ex_stage.sv
// Directed self-checking bench for r200ex_stage (MDU cases compiled in with R200EX_MDU_EN).
module tb_r200ex_stage;
  import r200_pkg::*;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MDU_CYCLES = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  r200ex_stage_if #(.XLEN(XLEN)) ex ();

  r200ex_stage #(
    .XLEN      (XLEN),
    .MDU_CYCLES(MDU_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ex   (ex)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic cont, input logic br, input logic mdu,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] ji, input logic [XLEN-1:0] ja);
    ex.in_valid    = 1'b1;
    ex.func3       = f3;
    ex.alu_cont    = cont;
    ex.is_branch   = br;
    ex.is_mdu      = mdu;
    ex.op1         = a;
    ex.op2         = b;
    ex.jump_imm    = ji;
    ex.jump_addimm = ja;
  endtask

  // Offers one op, checks it is taken, and returns one edge later with in_valid dropped.
  task automatic issue(input string tag, input logic [2:0] f3, input logic cont, input logic br,
                       input logic mdu, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    drive(f3, cont, br, mdu, a, b, '0, '0);
    #1;
    chk({tag, "_in_ready"}, ex.in_ready, 1'b1);
    tick();
    ex.in_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [2:0] f3, input logic cont, input logic mdu,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    issue(tag, f3, cont, 1'b0, mdu, a, b);
    chk({tag, "_valid"}, ex.out_valid, 1'b1);
    chk(tag, ex.alu_res, exp);
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic br,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic exp);
    issue(tag, f3, 1'b0, br, 1'b0, a, b);
    chk(tag, ex.willbr, exp);
  endtask

`ifdef R200EX_MDU_EN
  task automatic run_mdu(input string tag, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    issue(tag, f3, 1'b0, 1'b0, 1'b1, a, b);
    repeat (MDU_CYCLES - 1) tick();
    chk({tag, "_early"}, ex.out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, ex.out_valid, 1'b1);
    chk(tag, ex.alu_res, exp);
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    ex.in_valid    = 1'b0;
    ex.func3       = '0;
    ex.alu_cont    = 1'b0;
    ex.is_branch   = 1'b0;
    ex.is_mdu      = 1'b0;
    ex.op1         = '0;
    ex.op2         = '0;
    ex.jump_imm    = '0;
    ex.jump_addimm = '0;
    ex.flush       = 1'b0;
    ex.out_ready   = 1'b1;

    #12;
    chk("rst_in_ready", ex.in_ready, 1'b0);
    chk("rst_out_valid", ex.out_valid, 1'b0);
    chk("rst_alu_res", ex.alu_res, '0);
    chk("rst_pc", ex.pc_jumptarg, '0);
    chk("rst_willbr", ex.willbr, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", ex.in_ready, 1'b1);

    // back-to-back ALU ops, one per cycle
    run_alu("add",  F3_ADD,  1'b0, 1'b0, 32'd5, 32'd7, 32'h0000_000C);
    run_alu("sub",  F3_ADD,  1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_alu("sll",  F3_SLL,  1'b0, 1'b0, 32'd1, 32'd33, 32'h0000_0002);
    run_alu("slt",  F3_SLT,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001);
    run_alu("sltu", F3_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    run_alu("xor",  F3_XOR,  1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_alu("srl",  F3_SRL,  1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_alu("sra",  F3_SRL,  1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_alu("or",   F3_OR,   1'b0, 1'b0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF);
    run_alu("and",  F3_AND,  1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);

    run_br("blt",     F3_BLT,  1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_br("bltu",    F3_BLTU, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_br("bge",     F3_BGE,  1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_br("bgeu",    F3_BGEU, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_br("beq",     F3_BEQ,  1'b1, 32'd3, 32'd3, 1'b1);
    run_br("bne",     F3_BNE,  1'b1, 32'd3, 32'd3, 1'b0);
    run_br("br_010",  3'b010,  1'b1, 32'd3, 32'd3, 1'b0);
    run_br("beq_nobr", F3_BEQ, 1'b0, 32'd3, 32'd3, 1'b0);

    tick();
    chk("drain_valid", ex.out_valid, 1'b0);

    // jump target wrap and output hold under backpressure
    ex.out_ready = 1'b0;
    drive(F3_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h0000_0020);
    tick();
    ex.in_valid = 1'b0;
    chk("pc_valid", ex.out_valid, 1'b1);
    chk("pc_targ", ex.pc_jumptarg, 32'h0000_0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", ex.out_valid, 1'b1);
      chk("hold_alu", ex.alu_res, 32'h0000_0003);
      chk("hold_pc", ex.pc_jumptarg, 32'h0000_0010);
      chk("hold_in_ready", ex.in_ready, 1'b0);
    end
    ex.out_ready = 1'b1;
    #1;
    chk("pop_in_ready", ex.in_ready, 1'b1);
    tick();
    chk("pop_valid", ex.out_valid, 1'b0);

    // flush drops a held result and refuses a simultaneous offer
    ex.out_ready = 1'b0;
    issue("fl_pre", F3_ADD, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2);
    chk("fl_pre_alu", ex.alu_res, 32'h0000_0004);
    ex.flush = 1'b1;
    drive(F3_ADD, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, '0, '0);
    #1;
    chk("fl_in_ready", ex.in_ready, 1'b0);
    tick();
    chk("fl_valid", ex.out_valid, 1'b0);
    chk("fl_not_taken", ex.alu_res, 32'h0000_0004);
    ex.flush    = 1'b0;
    ex.in_valid = 1'b0;
    #1;
    chk("fl_in_ready_after", ex.in_ready, 1'b1);
    ex.out_ready = 1'b1;

`ifndef R200EX_MDU_EN
    run_alu("mdu_ignored", F3_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 32'h0000_000C);
    tick();

    // async reset while a result is held
    ex.out_ready = 1'b0;
    issue("rst_pre", F3_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", ex.out_valid, 1'b0);
    chk("rst2_alu", ex.alu_res, '0);
    chk("rst2_in_ready", ex.in_ready, 1'b0);
    tick();
    rst_n        = 1'b1;
    ex.out_ready = 1'b1;
    run_alu("rst2_add", F3_ADD, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0000_000C);
`else
    run_mdu("div_ovf", F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mdu("rem_ovf", F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_mdu("divu_0",  F3_DIVU,  32'd7, 32'd0, 32'hFFFF_FFFF);
    run_mdu("rem_0",   F3_REM,   32'd7, 32'd0, 32'h0000_0007);
    run_mdu("div_neg", F3_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mdu("rem_neg", F3_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mdu("mul",     F3_MUL,   32'd6, 32'd7, 32'h0000_002A);
    run_mdu("mulh",    F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_mdu("mulhu",   F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mdu("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();

    // flush during the fifth BUSY cycle
    issue("mfl", F3_DIV, 1'b0, 1'b0, 1'b1, 32'd100, 32'd7);
    repeat (4) tick();
    chk("mfl_busy_in_ready", ex.in_ready, 1'b0);
    ex.flush = 1'b1;
    drive(F3_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, '0, '0);
    #1;
    chk("mfl_in_ready", ex.in_ready, 1'b0);
    tick();
    chk("mfl_valid", ex.out_valid, 1'b0);
    ex.flush    = 1'b0;
    ex.in_valid = 1'b0;
    #1;
    chk("mfl_idle", ex.in_ready, 1'b1);
    repeat (MDU_CYCLES) tick();
    chk("mfl_no_result", ex.out_valid, 1'b0);

    // async reset in the middle of a divide
    issue("mrst", F3_DIV, 1'b0, 1'b0, 1'b1, 32'd100, 32'd7);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", ex.out_valid, 1'b0);
    chk("mrst_alu", ex.alu_res, '0);
    chk("mrst_pc", ex.pc_jumptarg, '0);
    chk("mrst_willbr", ex.willbr, 1'b0);
    chk("mrst_in_ready", ex.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    run_alu("mrst_add", F3_ADD, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0000_000C);
    repeat (MDU_CYCLES) tick();
    chk("mrst_no_result", ex.out_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
